// File: rtl/soc_mem_bus.sv
// Native-memory-interface slave for picorv32 test SoCs: byte-lane RAM, console FIFO, status register.
// Optional monitor outputs are built when SOC_MEM_MONITOR_EN is defined; otherwise they are tied to 0.
module soc_mem_bus #(
  parameter int          MEM_WORDS     = 16384,
  parameter              MEM_INIT_FILE = "",
  parameter int          WAIT_STATES   = 0,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [31:0] CONSOLE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR   = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  out_byte,
  output logic        out_byte_valid,
  input  logic        out_byte_ready,
  output logic        fifo_overflow,
  output logic        bus_error,
  output logic        monitor_valid,
  output logic [31:0] monitor_addr,
  output logic [31:0] monitor_data,
  output logic        monitor_instr
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0]    WS_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          bus_err_q, bus_err_d;

  logic          accept;
  logic          enter_resp;
  logic          in_resp;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic [29:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic          hit_console;
  logic          hit_status;
  logic          hit_ram;
  logic [31:0]   status_word;
  logic [31:0]   rd_value;
  logic          fifo_valid;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          ram_we;

  // In IDLE the request is still on the bus; afterwards decode runs from the latched copy.
  assign accept    = (state_q == S_IDLE) && mem_valid;
  assign in_resp   = (state_q == S_RESP);
  assign req_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
  assign req_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
  assign req_wstrb = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;

  assign word_idx    = req_addr[31:2];
  assign ram_idx     = word_idx[AW-1:0];
  assign hit_console = (word_idx == CONSOLE_ADDR[31:2]);
  assign hit_status  = (word_idx == STATUS_ADDR[31:2]);
  assign hit_ram     = !hit_console && !hit_status && ({2'b00, word_idx} < 32'(MEM_WORDS));

  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == CNT_FULL);

  always_comb begin
    status_word       = '0;
    status_word[0]    = !fifo_valid;
    status_word[1]    = fifo_full;
    status_word[2]    = overflow_q;
    status_word[3]    = bus_err_q;
    status_word[15:8] = 8'(count_q);
  end

  always_comb begin
    if (hit_console)     rd_value = '0;
    else if (hit_status) rd_value = status_word;
    else if (hit_ram)    rd_value = ram[ram_idx];
    else                 rd_value = 32'hDEAD_BEEF;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = '0;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdata_d = enter_resp ? rd_value : '0;
  end

  // A push into a full FIFO survives only when the head is popped on the same edge.
  always_comb begin
    push       = in_resp && hit_console && (wstrb_q != '0);
    pop        = fifo_valid && out_byte_ready;
    push_ok    = push && (!fifo_full || pop);
    wr_ptr_d   = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop) count_d = count_q - CNT_ONE;
    overflow_d = overflow_q || (push && fifo_full && !pop);
    bus_err_d  = bus_err_q || (in_resp && !hit_console && !hit_status && !hit_ram);
  end

  assign ram_we = in_resp && hit_ram && (wstrb_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Storage arrays carry no reset; the reset guard only blocks a commit on an abandoned RESP.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr_q] <= wdata_q[7:0];
  end

  assign mem_ready      = in_resp;
  assign mem_rdata      = rdata_q;
  assign out_byte_valid = fifo_valid;
  assign out_byte       = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
  assign fifo_overflow  = overflow_q;
  assign bus_error      = bus_err_q;

`ifdef SOC_MEM_MONITOR_EN
  logic        instr_q, instr_d;
  logic [31:0] mon_addr_q, mon_addr_d;
  logic [31:0] mon_data_q, mon_data_d;
  logic        mon_instr_q, mon_instr_d;

  always_comb begin
    instr_d     = accept ? mem_instr : instr_q;
    mon_addr_d  = '0;
    mon_data_d  = '0;
    mon_instr_d = 1'b0;
    if (enter_resp) begin
      mon_addr_d  = req_addr;
      mon_data_d  = (req_wstrb != '0) ? req_wdata : rd_value;
      mon_instr_d = (state_q == S_IDLE) ? mem_instr : instr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= 1'b0;
      mon_addr_q  <= '0;
      mon_data_q  <= '0;
      mon_instr_q <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      mon_addr_q  <= mon_addr_d;
      mon_data_q  <= mon_data_d;
      mon_instr_q <= mon_instr_d;
    end
  end

  assign monitor_valid = in_resp;
  assign monitor_addr  = mon_addr_q;
  assign monitor_data  = mon_data_q;
  assign monitor_instr = mon_instr_q;
`else
  logic unused_mon;
  assign unused_mon    = ^{mem_instr, req_addr[1:0], accept};
  assign monitor_valid = 1'b0;
  assign monitor_addr  = '0;
  assign monitor_data  = '0;
  assign monitor_instr = 1'b0;
`endif

endmodule

// File: tb/tb_soc_mem_bus.sv
// Directed self-checking bench for soc_mem_bus (WAIT_STATES=3, FIFO_DEPTH=4).
module tb_soc_mem_bus;

  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] STAT_A = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  out_byte;
  logic        out_byte_valid;
  logic        out_byte_ready = 1'b0;
  logic        fifo_overflow;
  logic        bus_error;
  logic        monitor_valid;
  logic [31:0] monitor_addr;
  logic [31:0] monitor_data;
  logic        monitor_instr;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_rdata, cap_maddr, cap_mdata;
  logic        cap_mvalid, cap_minstr;
  int          cap_lat;
  bit          cap_ok;

  soc_mem_bus #(
    .MEM_WORDS    (1024),
    .MEM_INIT_FILE(""),
    .WAIT_STATES  (3),
    .FIFO_DEPTH   (4),
    .CONSOLE_ADDR (CON_A),
    .STATUS_ADDR  (STAT_A)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .out_byte      (out_byte),
    .out_byte_valid(out_byte_valid),
    .out_byte_ready(out_byte_ready),
    .fifo_overflow (fifo_overflow),
    .bus_error     (bus_error),
    .monitor_valid (monitor_valid),
    .monitor_addr  (monitor_addr),
    .monitor_data  (monitor_data),
    .monitor_instr (monitor_instr)
  );

  always #5 clk = ~clk;

  // Bus driver: inputs are scrambled after acceptance, valid drops once mem_ready is seen.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic ins, input bit pop_in_resp);
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
    @(posedge clk); #1;
    mem_addr = a ^ 32'h0000_0004; mem_wdata = ~wd; mem_instr = ~ins;
    cap_lat = 0; cap_ok = 0;
    for (int i = 0; i < 40; i++) begin
      cap_lat++;
      if (mem_ready) begin
        cap_ok = 1; cap_rdata = mem_rdata;
        cap_mvalid = monitor_valid; cap_maddr = monitor_addr;
        cap_mdata = monitor_data; cap_minstr = monitor_instr;
        break;
      end
      @(posedge clk); #1;
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    if (!cap_ok) begin
      checks++; errors++;
      $display("FAIL xfer_timeout addr=%h: no mem_ready within 40 cycles", a);
    end else if (pop_in_resp) begin
      out_byte_ready = 1'b1;
      @(posedge clk); #1;
      out_byte_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_bus: ready=%b rdata=%h required 0/0", mem_ready, mem_rdata); end
    checks++; if (out_byte_valid !== 1'b0 || out_byte !== 8'h0) begin errors++;
      $display("FAIL reset_fifo: valid=%b byte=%h required 0/00", out_byte_valid, out_byte); end
    checks++; if (fifo_overflow !== 1'b0 || bus_error !== 1'b0) begin errors++;
      $display("FAIL reset_flags: ovf=%b berr=%b required 0/0", fifo_overflow, bus_error); end
    checks++; if ({monitor_valid, monitor_instr, monitor_addr, monitor_data} !== '0) begin errors++;
      $display("FAIL reset_monitor: v=%b i=%b a=%h d=%h required all 0",
               monitor_valid, monitor_instr, monitor_addr, monitor_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ram_latency;
    xfer(32'h100, 32'h0, 4'hF, 1'b0, 0);
    xfer(32'h100, 32'h1234_5678, 4'b0101, 1'b0, 0);
    checks++; if (cap_lat !== 4) begin errors++;
      $display("FAIL write_latency: got %0d cycles required 4", cap_lat); end
    xfer(32'h100, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h0034_0078) begin errors++;
      $display("FAIL ram_lane_0101: got %h required 00340078", cap_rdata); end
    checks++; if (cap_lat !== 4) begin errors++;
      $display("FAIL read_latency: got %0d cycles required 4", cap_lat); end
    @(posedge clk); #1;
    checks++; if (mem_rdata !== 32'h0 || mem_ready !== 1'b0) begin errors++;
      $display("FAIL rdata_after_resp: rdata=%h ready=%b required 0/0", mem_rdata, mem_ready); end
    xfer(32'h103, 32'hAABB_CCDD, 4'b1010, 1'b0, 0);
    xfer(32'h100, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'hAA34_CC78) begin errors++;
      $display("FAIL ram_lane_1010: got %h required aa34cc78", cap_rdata); end
  endtask

  task automatic test_console_flow;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    out_byte_ready = 1'b0;
    xfer(CON_A, 32'hFFFF_FF41, 4'b0001, 1'b0, 0);
    checks++; if (out_byte_valid !== 1'b0) begin errors++;
      $display("FAIL push_latency_resp: valid=%b required 0 during RESP", out_byte_valid); end
    @(posedge clk); #1;
    checks++; if (out_byte_valid !== 1'b1 || out_byte !== 8'h41) begin errors++;
      $display("FAIL push_latency_next: valid=%b byte=%h required 1/41", out_byte_valid, out_byte); end
    xfer(CON_A, 32'h0000_0042, 4'b1000, 1'b0, 0);
    xfer(CON_A, 32'h0000_0043, 4'b0001, 1'b0, 0);
    xfer(STAT_A, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h0000_0300) begin errors++;
      $display("FAIL status_count3: got %h required 00000300", cap_rdata); end
    xfer(CON_A, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h0) begin errors++;
      $display("FAIL console_read: got %h required 00000000", cap_rdata); end
    out_byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_byte_valid !== 1'b1 || out_byte !== exp_b[i]) begin errors++;
        $display("FAIL drain_%0d: valid=%b byte=%h required 1/%h", i, out_byte_valid, out_byte, exp_b[i]); end
      @(posedge clk);
    end
    #1;
    out_byte_ready = 1'b0;
    checks++; if (out_byte_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty: valid=%b required 0", out_byte_valid); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] exp_a [4];
    for (int i = 0; i < 4; i++) xfer(CON_A, 32'h61 + 32'(i), 4'b0001, 1'b0, 0);
    xfer(CON_A, 32'h65, 4'b0001, 1'b0, 1);
    xfer(STAT_A, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h0000_0402) begin errors++;
      $display("FAIL push_pop_full_status: got %h required 00000402", cap_rdata); end
    exp_a[0] = 8'h62; exp_a[1] = 8'h63; exp_a[2] = 8'h64; exp_a[3] = 8'h65;
    out_byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_byte_valid !== 1'b1 || out_byte !== exp_a[i]) begin errors++;
        $display("FAIL push_pop_full_drain_%0d: byte=%h required %h", i, out_byte, exp_a[i]); end
      @(posedge clk); #1;
    end
    out_byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) xfer(CON_A, 32'h51 + 32'(i), 4'b0001, 1'b0, 0);
    xfer(STAT_A, 32'hFFFF_FFFF, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h0000_0406) begin errors++;
      $display("FAIL overflow_status: got %h required 00000406", cap_rdata); end
    checks++; if (fifo_overflow !== 1'b1) begin errors++;
      $display("FAIL overflow_flag: got %b required 1", fifo_overflow); end
    exp_a[0] = 8'h51; exp_a[1] = 8'h52; exp_a[2] = 8'h53; exp_a[3] = 8'h54;
    out_byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_byte_valid !== 1'b1 || out_byte !== exp_a[i]) begin errors++;
        $display("FAIL overflow_drain_%0d: byte=%h required %h", i, out_byte, exp_a[i]); end
      @(posedge clk); #1;
    end
    out_byte_ready = 1'b0;
    checks++; if (out_byte_valid !== 1'b0 || fifo_overflow !== 1'b1) begin errors++;
      $display("FAIL overflow_sticky: valid=%b ovf=%b required 0/1", out_byte_valid, fifo_overflow); end
  endtask

  task automatic test_unmapped;
    checks++; if (bus_error !== 1'b0) begin errors++;
      $display("FAIL berr_before: got %b required 0", bus_error); end
    xfer(32'h2000_0000, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL unmapped_read: got %h required deadbeef", cap_rdata); end
    @(posedge clk); #1;
    checks++; if (bus_error !== 1'b1) begin errors++;
      $display("FAIL berr_set: got %b required 1", bus_error); end
    xfer(32'h0000_1000, 32'h5555_5555, 4'hF, 1'b0, 0);
    xfer(32'h100, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (bus_error !== 1'b1 || cap_rdata !== 32'hAA34_CC78) begin errors++;
      $display("FAIL berr_sticky: berr=%b rdata=%h required 1/aa34cc78", bus_error, cap_rdata); end
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    xfer(32'h100, 32'h1122_3344, 4'hF, 1'b0, 0);
    xfer(CON_A, 32'h77, 4'b0001, 1'b0, 0);
    @(posedge clk); @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_ready !== 1'b0 || out_byte_valid !== 1'b1 || bus_error !== 1'b1) begin errors++;
      $display("FAIL pre_reset_state: ready=%b valid=%b berr=%b required 0/1/1",
               mem_ready, out_byte_valid, bus_error); end
    reset = 1'b1; mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    checks++; if ({mem_ready, mem_rdata, out_byte_valid, out_byte, fifo_overflow, bus_error,
                   monitor_valid, monitor_addr, monitor_data, monitor_instr} !== '0) begin errors++;
      $display("FAIL mid_reset_outputs: ready=%b rdata=%h valid=%b byte=%h ovf=%b berr=%b required all 0",
               mem_ready, mem_rdata, out_byte_valid, out_byte, fifo_overflow, bus_error); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL abandoned_ready: saw mem_ready=%b required 0", seen); end
    xfer(32'h100, 32'h0, 4'h0, 1'b0, 0);
    checks++; if (cap_rdata !== 32'h1122_3344) begin errors++;
      $display("FAIL abandoned_write: got %h required 11223344", cap_rdata); end
  endtask

  task automatic test_monitor;
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    logic        exp_v;
    logic        exp_i;
    xfer(32'h0, 32'hCAFE_0001, 4'hF, 1'b0, 0);
    xfer(32'h0, 32'h0, 4'h0, 1'b1, 0);
`ifdef SOC_MEM_MONITOR_EN
    exp_v = 1'b1; exp_i = 1'b1; exp_d = 32'hCAFE_0001; exp_a = 32'h0;
`else
    exp_v = 1'b0; exp_i = 1'b0; exp_d = 32'h0; exp_a = 32'h0;
`endif
    checks++; if (cap_rdata !== 32'hCAFE_0001) begin errors++;
      $display("FAIL fetch_rdata: got %h required cafe0001", cap_rdata); end
    checks++; if (cap_mvalid !== exp_v || cap_minstr !== exp_i || cap_mdata !== exp_d || cap_maddr !== exp_a) begin errors++;
      $display("FAIL monitor_fetch: v=%b i=%b a=%h d=%h required %b/%b/%h/%h",
               cap_mvalid, cap_minstr, cap_maddr, cap_mdata, exp_v, exp_i, exp_a, exp_d); end
    xfer(32'h106, 32'h0BAD_F00D, 4'b0011, 1'b0, 0);
`ifdef SOC_MEM_MONITOR_EN
    exp_v = 1'b1; exp_i = 1'b0; exp_d = 32'h0BAD_F00D; exp_a = 32'h106;
`endif
    checks++; if (cap_mvalid !== exp_v || cap_minstr !== exp_i || cap_mdata !== exp_d || cap_maddr !== exp_a) begin errors++;
      $display("FAIL monitor_write: v=%b i=%b a=%h d=%h required %b/%b/%h/%h",
               cap_mvalid, cap_minstr, cap_maddr, cap_mdata, exp_v, exp_i, exp_a, exp_d); end
  endtask

  initial begin
    test_reset;
    test_ram_latency;
    test_console_flow;
    test_fifo_full;
    test_unmapped;
    test_reset_mid_wait;
    test_monitor;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
